move_link_rx: RTL

//  Receive end of the inter-board move link. Deserialises the opponent board's one-wire move

---
 rtl/move_link_rx.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/move_link_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : move_link_rx                                               |
// | Description : Receive end of the inter-board move link. Deserialises a   |
// |               one-wire frame (start, LSB-first column, even parity,      |
// |               stop) into a validated column index and flags bad frames.  |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module move_link_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int COL_W        = 3,
  parameter int NUM_COLS     = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             link_up,
  input  logic             rx_in,
  output logic             move_valid,
  output logic [COL_W-1:0] move_col,
  output logic             frame_err,
  output logic             busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = (COL_W > 1) ? $clog2(COL_W) : 1;
  localparam int VAL_W = COL_W + 1;

  localparam logic [CNT_W-1:0] c_cnt_half = CNT_W'(CLKS_PER_BIT/2 - 1);
  localparam logic [CNT_W-1:0] c_cnt_full = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
  localparam logic [IDX_W-1:0] c_idx_last = IDX_W'(COL_W - 1);
  localparam logic [IDX_W-1:0] c_idx_one  = IDX_W'(1);
  // one extra bit so NUM_COLS == 2**COL_W is still representable
  localparam logic [VAL_W-1:0] c_num_cols = VAL_W'(NUM_COLS);

  localparam logic [2:0] c_st_idle    = 3'd0;
  localparam logic [2:0] c_st_start   = 3'd1;
  localparam logic [2:0] c_st_data    = 3'd2;
  localparam logic [2:0] c_st_parity  = 3'd3;
  localparam logic [2:0] c_st_stop    = 3'd4;
  localparam logic [2:0] c_st_wait_hi = 3'd5;

  logic             r_sync1;
  logic             r_sync2;
  logic             w_rx_s;
  logic [2:0]       r_state;
  logic [2:0]       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [IDX_W-1:0] r_idx;
  logic [COL_W-1:0] r_shreg;
  logic             r_par;
  logic             w_half;
  logic             w_full;
  logic             w_busy;
  logic             w_stop_smp;
  logic             w_frame_ok;
  logic             w_valid_nxt;
  logic             w_err_nxt;
  logic             r_move_valid;
  logic             r_frame_err;
  logic [COL_W-1:0] r_move_col;

  assign w_rx_s = r_sync2;
  assign w_half = (r_cnt == c_cnt_half);
  assign w_full = (r_cnt == c_cnt_full);

  // Two-flop synchroniser for the asynchronous peer line; resets to idle-high
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx_in;
      r_sync2 <= r_sync1;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; a dropped link overrides everything and parks in IDLE
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle:    if (!w_rx_s) w_state_nxt = c_st_start;
      c_st_start:   if (w_half)  w_state_nxt = w_rx_s ? c_st_idle : c_st_data;
      c_st_data:    if (w_full && (r_idx == c_idx_last)) w_state_nxt = c_st_parity;
      c_st_parity:  if (w_full)  w_state_nxt = c_st_stop;
      c_st_stop:    if (w_full)  w_state_nxt = w_rx_s ? c_st_idle : c_st_wait_hi;
      c_st_wait_hi: if (w_rx_s)  w_state_nxt = c_st_idle;
      default:      w_state_nxt = c_st_idle;
    endcase
    if (!link_up) begin
      w_state_nxt = c_st_idle;
    end
  end

  // Output decode: frame verdict is formed on the stop-bit sample edge
  always_comb begin
    w_busy      = (r_state != c_st_idle);
    w_stop_smp  = (r_state == c_st_stop) && w_full && link_up;
    w_frame_ok  = w_rx_s && !(^{r_shreg, r_par}) && ({1'b0, r_shreg} < c_num_cols);
    w_valid_nxt = w_stop_smp && w_frame_ok;
    w_err_nxt   = w_stop_smp && !w_frame_ok;
  end

  // Bit timing counter, data index, shift register and captured parity bit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shreg <= '0;
      r_par   <= 1'b0;
    end else begin
      // restart timing on every state change and at each mid-bit sample
      if ((w_state_nxt != r_state) || w_full ||
          (r_state == c_st_idle) || (r_state == c_st_wait_hi)) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + c_cnt_one;
      end
      if (r_state == c_st_start) begin
        r_idx <= '0;
      end
      if ((r_state == c_st_data) && w_full) begin
        r_shreg[r_idx] <= w_rx_s;
        r_idx          <= r_idx + c_idx_one;
      end
      if ((r_state == c_st_parity) && w_full) begin
        r_par <= w_rx_s;
      end
    end
  end

  // Registered result pulses; move_col only updates on an accepted frame
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_move_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      r_move_col   <= '0;
    end else begin
      r_move_valid <= w_valid_nxt;
      r_frame_err  <= w_err_nxt;
      if (w_valid_nxt) begin
        r_move_col <= r_shreg;
      end
    end
  end

  assign move_valid = r_move_valid;
  assign frame_err  = r_frame_err;
  assign move_col   = r_move_col;
  assign busy       = w_busy;

endmodule
`default_nettype wire
